// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage (master) and the
// data memory (slave).
interface mem_access_stage_if;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_access_stage.sv
// MEM-stage controller: data-memory handshake with timeout abort, pipeline stall,
// branch resolution, sticky memory-error flag and the MEM/WB register.
module mem_access_stage #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       EM_MemRead,
    input  logic                       EM_MemWrite,
    input  logic                       EM_MemtoReg,
    input  logic                       EM_RegWrite,
    input  logic                       EM_Branch,
    input  logic                       EM_zero,
    input  logic [4:0]                 EM_rd,
    input  logic [63:0]                EM_Result,
    input  logic [63:0]                EM_out,
    input  logic [63:0]                EM_WriteData,
    mem_access_stage_if.master         mem,
    output logic                       stall,
    output logic                       PCSrc,
    output logic [63:0]                branch_target,
    output logic                       MW_RegWrite,
    output logic                       MW_MemtoReg,
    output logic [4:0]                 MW_rd,
    output logic [63:0]                MW_ReadData,
    output logic [63:0]                MW_Result,
    output logic                       mem_err
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ABORT} state_e;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_e      state_q, state_d;
    logic [7:0]  wcnt_q, wcnt_d;
    logic        err_q, err_d;
    logic        mw_regwrite_q, mw_regwrite_d;
    logic        mw_memtoreg_q, mw_memtoreg_d;
    logic [4:0]  mw_rd_q, mw_rd_d;
    logic [63:0] mw_readdata_q, mw_readdata_d;
    logic [63:0] mw_result_q, mw_result_d;

    logic acc, illegal, legal_acc;
    logic req, kill, load_hit;

    assign acc       = EM_MemRead | EM_MemWrite;
    assign illegal   = (EM_MemRead & EM_MemWrite) | (acc & (EM_Result[2:0] != 3'b000));
    assign legal_acc = acc & ~illegal;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            S_IDLE: begin
                if (legal_acc && !mem.mem_ack) begin
                    state_d = S_WAIT;
                    wcnt_d  = 8'd1;
                end
            end
            S_WAIT: begin
                if (mem.mem_ack) begin
                    state_d = S_IDLE;
                    wcnt_d  = '0;
                end else if (wcnt_q == TIMEOUT_CNT) begin
                    state_d = S_ABORT;
                end else begin
                    wcnt_d = wcnt_q + 8'd1;
                end
            end
            S_ABORT: begin
                state_d = S_IDLE;
                wcnt_d  = '0;
            end
            default: begin
                state_d = S_IDLE;
                wcnt_d  = '0;
            end
        endcase
    end

    // kill marks an instruction that retires without a register write:
    // an illegal access seen in IDLE, or the held access at abort.
    always_comb begin
        req   = 1'b0;
        stall = 1'b0;
        kill  = 1'b0;
        case (state_q)
            S_IDLE: begin
                req   = legal_acc;
                stall = legal_acc & ~mem.mem_ack;
                kill  = illegal;
            end
            S_WAIT: begin
                req   = 1'b1;
                stall = ~mem.mem_ack;
            end
            S_ABORT: kill = 1'b1;
            default: ;
        endcase
        // Request and stall must drop the instant reset rises, not at the next edge.
        if (reset) begin
            req   = 1'b0;
            stall = 1'b0;
        end
    end

    assign load_hit = req & mem.mem_ack & ~EM_MemWrite;

    always_comb begin
        err_d         = err_q | kill;
        mw_regwrite_d = EM_RegWrite & ~kill;
        mw_memtoreg_d = EM_MemtoReg;
        mw_rd_d       = EM_rd;
        mw_result_d   = EM_Result;
        mw_readdata_d = load_hit ? mem.mem_rdata : '0;
        // A stalled edge inserts a bubble into write-back.
        if (stall) begin
            mw_regwrite_d = 1'b0;
            mw_memtoreg_d = 1'b0;
            mw_rd_d       = '0;
            mw_result_d   = '0;
            mw_readdata_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q         <= 1'b0;
            mw_regwrite_q <= 1'b0;
            mw_memtoreg_q <= 1'b0;
            mw_rd_q       <= '0;
            mw_result_q   <= '0;
            mw_readdata_q <= '0;
        end else begin
            err_q         <= err_d;
            mw_regwrite_q <= mw_regwrite_d;
            mw_memtoreg_q <= mw_memtoreg_d;
            mw_rd_q       <= mw_rd_d;
            mw_result_q   <= mw_result_d;
            mw_readdata_q <= mw_readdata_d;
        end
    end

    assign mem.mem_req   = req;
    assign mem.mem_we    = EM_MemWrite;
    assign mem.mem_addr  = EM_Result;
    assign mem.mem_wdata = EM_WriteData;

    assign PCSrc         = EM_Branch & EM_zero;
    assign branch_target = EM_out;

    assign MW_RegWrite = mw_regwrite_q;
    assign MW_MemtoReg = mw_memtoreg_q;
    assign MW_rd       = mw_rd_q;
    assign MW_ReadData = mw_readdata_q;
    assign MW_Result   = mw_result_q;
    assign mem_err     = err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized bench for mem_access_stage: each instruction is run as a whole
// transaction against a model of stall length, handshake and MEM/WB result.
module tb_mem_access_stage;

    localparam int T = 4;

    typedef struct {
        logic        rd, wr, regw, m2r, br, z;
        logic [4:0]  rdn;
        logic [63:0] res, tgt, wdata;
    } instr_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        EM_MemRead, EM_MemWrite, EM_MemtoReg, EM_RegWrite, EM_Branch, EM_zero;
    logic [4:0]  EM_rd;
    logic [63:0] EM_Result, EM_out, EM_WriteData;
    logic        stall, PCSrc, MW_RegWrite, MW_MemtoReg, mem_err;
    logic [63:0] branch_target, MW_ReadData, MW_Result;
    logic [4:0]  MW_rd;

    int n_tests = 0;
    int n_fail  = 0;
    bit err_m   = 1'b0;

    mem_access_stage_if mem_bus ();

    mem_access_stage #(.TIMEOUT(T)) dut (
        .clk(clk), .reset(reset),
        .EM_MemRead(EM_MemRead), .EM_MemWrite(EM_MemWrite), .EM_MemtoReg(EM_MemtoReg),
        .EM_RegWrite(EM_RegWrite), .EM_Branch(EM_Branch), .EM_zero(EM_zero),
        .EM_rd(EM_rd), .EM_Result(EM_Result), .EM_out(EM_out), .EM_WriteData(EM_WriteData),
        .mem(mem_bus), .stall(stall), .PCSrc(PCSrc), .branch_target(branch_target),
        .MW_RegWrite(MW_RegWrite), .MW_MemtoReg(MW_MemtoReg), .MW_rd(MW_rd),
        .MW_ReadData(MW_ReadData), .MW_Result(MW_Result), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input instr_t i);
        EM_MemRead   = i.rd;
        EM_MemWrite  = i.wr;
        EM_RegWrite  = i.regw;
        EM_MemtoReg  = i.m2r;
        EM_Branch    = i.br;
        EM_zero      = i.z;
        EM_rd        = i.rdn;
        EM_Result    = i.res;
        EM_out       = i.tgt;
        EM_WriteData = i.wdata;
    endtask

    task automatic check_mw_zero(input string tag);
        check({tag, "_ctl"}, {57'd0, MW_RegWrite, MW_MemtoReg, MW_rd}, 64'd0);
        check({tag, "_res"}, MW_Result, 64'd0);
        check({tag, "_rdata"}, MW_ReadData, 64'd0);
    endtask

    // Runs one instruction to retirement. d is the cycle (counted from the first
    // request cycle) in which memory acks; d > T means it never does.
    task automatic run_instr(input instr_t i, input int d);
        bit          acc, illegal, legal, timeout, ack;
        int          ncyc;
        logic [63:0] rdata_v, exp_rdata;
        acc     = i.rd | i.wr;
        illegal = (i.rd & i.wr) | (acc && i.res[2:0] != 3'b000);
        legal   = acc && !illegal;
        timeout = legal && d > T;
        ncyc    = !legal ? 1 : (timeout ? T + 2 : d + 1);
        rdata_v = {$urandom, $urandom};
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            drive(i);
            if (legal && !(timeout && k == ncyc - 1))
                ack = (k == d);
            else
                ack = ($urandom_range(0, 2) == 0);
            mem_bus.mem_ack   = ack;
            mem_bus.mem_rdata = ack ? rdata_v : {$urandom, $urandom};
            #1;
            check("req", mem_bus.mem_req, legal && !(timeout && k == ncyc - 1));
            check("stall", stall, legal && k < ncyc - 1);
            if (legal && mem_bus.mem_req) begin
                check("addr", mem_bus.mem_addr, i.res);
                check("we", mem_bus.mem_we, i.wr);
                check("wdata", mem_bus.mem_wdata, i.wdata);
            end
            check("pcsrc", PCSrc, i.br & i.z);
            check("target", branch_target, i.tgt);
            @(posedge clk);
            #1;
            if (k < ncyc - 1) begin
                check_mw_zero("bubble");
            end else begin
                exp_rdata = (legal && !timeout && i.rd) ? rdata_v : 64'd0;
                check("mw_regwrite", MW_RegWrite, (illegal || timeout) ? 1'b0 : i.regw);
                check("mw_memtoreg", MW_MemtoReg, i.m2r);
                check("mw_rd", MW_rd, i.rdn);
                check("mw_result", MW_Result, i.res);
                check("mw_readdata", MW_ReadData, exp_rdata);
                err_m = err_m | illegal | timeout;
                check("mem_err", mem_err, err_m);
            end
        end
    endtask

    function automatic instr_t mk(input logic rd, wr, regw, m2r, br, z,
                                  input logic [4:0] rdn, input logic [63:0] res, tgt, wdata);
        instr_t i;
        i.rd = rd; i.wr = wr; i.regw = regw; i.m2r = m2r; i.br = br; i.z = z;
        i.rdn = rdn; i.res = res; i.tgt = tgt; i.wdata = wdata;
        return i;
    endfunction

    function automatic instr_t rand_instr();
        instr_t      i;
        int          kind;
        logic [63:0] addr;
        kind = $urandom_range(0, 9);
        addr = {$urandom, $urandom} & ~64'd7;
        i = mk(1'b0, 1'b0, 1'($urandom), 1'b0, 1'b0, 1'($urandom), 5'($urandom),
               {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
        case (kind)
            3, 4: begin i.rd = 1'b1; i.m2r = 1'b1; i.regw = 1'b1; i.res = addr; end
            5, 6: begin i.wr = 1'b1; i.res = addr; end
            7:    begin i.rd = 1'b1; i.regw = 1'b1; i.res = addr | 64'(3'($urandom_range(1, 7))); end
            8:    begin i.rd = 1'b1; i.wr = 1'b1; i.regw = 1'b1; i.res = addr; end
            9:    i.br = 1'b1;
            default: ;
        endcase
        return i;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        drive(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 64'd0));
        mem_bus.mem_ack   = 1'b0;
        mem_bus.mem_rdata = 64'd0;
        #1;
        check("rst_req", mem_bus.mem_req, 1'b0);
        check("rst_stall", stall, 1'b0);
        check("rst_err", mem_err, 1'b0);
        check_mw_zero("rst_mw");
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Directed cases: ALU op, zero-wait load, 3-wait store, timeout,
        // misaligned load, read+write together, then an access after the error.
        run_instr(mk(0, 0, 1, 0, 0, 0, 5'd5, 64'h1234, 64'h0, 64'h0), 0);
        run_instr(mk(1, 0, 1, 1, 0, 0, 5'd7, 64'h100, 64'h0, 64'h0), 0);
        run_instr(mk(0, 1, 0, 0, 0, 0, 5'd0, 64'h108, 64'h0, 64'hAA), 3);
        run_instr(mk(1, 0, 1, 1, 0, 0, 5'd9, 64'h200, 64'h0, 64'h0), 99);
        run_instr(mk(1, 0, 1, 1, 0, 0, 5'd3, 64'h103, 64'h0, 64'h0), 0);
        run_instr(mk(1, 1, 1, 1, 0, 0, 5'd4, 64'h110, 64'h0, 64'h0), 0);
        run_instr(mk(1, 0, 1, 1, 0, 0, 5'd6, 64'h118, 64'h0, 64'h0), T);

        for (int n = 0; n < 300; n++)
            run_instr(rand_instr(), $urandom_range(0, T + 2));

        // Reset in the second WAIT cycle of a load that never gets an ack.
        @(negedge clk);
        drive(mk(1, 0, 1, 1, 0, 0, 5'd2, 64'h300, 64'h0, 64'h0));
        mem_bus.mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("wait_req", mem_bus.mem_req, 1'b1);
        reset = 1'b1;
        #1;
        check("rstw_req", mem_bus.mem_req, 1'b0);
        check("rstw_stall", stall, 1'b0);
        check("rstw_err", mem_err, 1'b0);
        check_mw_zero("rstw_mw");
        @(negedge clk);
        reset = 1'b0;
        err_m = 1'b0;
        drive(mk(0, 0, 0, 0, 1, 1, 5'd0, 64'h0, 64'h400, 64'h0));
        #1;
        check("br_pcsrc", PCSrc, 1'b1);
        check("br_target", branch_target, 64'h400);
        check("br_req", mem_bus.mem_req, 1'b0);
        run_instr(mk(1, 0, 1, 1, 0, 0, 5'd8, 64'h500, 64'h0, 64'h0), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

MEM-stage controller of the 64-bit RISC-V pipeline: consumes the registered EX/MEM control and data bundle, drives a req/ack data-memory handshake for loads and stores, stalls the front of the pipeline while an access is outstanding, resolves branches, and registers the MEM/WB bundle for write-back. It sits between the EX/MEM pipeline register and the write-back mux. It is also the only block that writes the sticky memory-error flag.

## Interface
- TIMEOUT, 16, cycles a request may wait for mem_ack before abort; legal range 1..255.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high.
- EM_MemRead, EM_MemWrite, EM_MemtoReg, EM_RegWrite, EM_Branch, EM_zero  in  1 each  EX/MEM controls and ALU zero flag.
- EM_rd  in  5  destination register.
- EM_Result  in  64  ALU result; memory address for loads and stores.
- EM_out  in  64  branch-target adder output.
- EM_WriteData  in  64  store data, already forwarded.
- mem_req  out  1  access request.
- mem_we  out  1  1 = store, 0 = load; valid while mem_req.
- mem_addr  out  64  equals EM_Result.
- mem_wdata  out  64  equals EM_WriteData.
- mem_rdata  in  64  load data; sampled only in an ack cycle.
- mem_ack  in  1  access complete; ignored when mem_req=0.
- stall  out  1  holds PC, IF/ID, ID/EX and EX/MEM.
- PCSrc  out  1  EM_Branch & EM_zero.
- branch_target  out  64  equals EM_out.
- MW_RegWrite, MW_MemtoReg  out  1 each  registered controls.
- MW_rd  out  5  registered destination.
- MW_ReadData  out  64  registered load data.
- MW_Result  out  64  registered ALU result.
- mem_err  out  1  sticky error flag; cleared only by reset.

## Operation
- An access is defined as `acc = EM_MemRead | EM_MemWrite`.
- Illegal access: EM_MemRead & EM_MemWrite both set, or `acc` with EM_Result[2:0] != 0 (misaligned doubleword).
  - mem_req stays 0 and stall stays 0.
  - mem_err is set at the next edge.
  - MEM/WB captures the instruction with MW_RegWrite=0 and MW_ReadData=0.
- FSM states: IDLE, WAIT, ABORT.
- IDLE:
  - Non-access instruction: no request, no stall; MEM/WB captures the bundle at the edge.
  - Legal access: mem_req=1 and mem_we=EM_MemWrite, combinationally in the same cycle.
  - mem_ack=1 in that cycle: stall=0, MEM/WB captures with MW_ReadData=mem_rdata, state stays IDLE.
  - Otherwise: stall=1, go to WAIT, wcnt<=1.
- WAIT:
  - mem_req=1; the inputs are held stable by the stall.
  - mem_ack=1: stall=0, MEM/WB captures the load data, go to IDLE, wcnt<=0.
  - No ack and wcnt==TIMEOUT: stall stays 1 this cycle, go to ABORT.
  - Otherwise wcnt increments.
- ABORT (one cycle):
  - mem_req=0 and stall=0.
  - mem_err is set.
  - MEM/WB captures with MW_RegWrite=0 and MW_ReadData=0.
  - Go to IDLE.
- Bubble rule: on every edge where stall=1, MEM/WB loads MW_RegWrite=0, MW_MemtoReg=0, MW_rd=0; MW_Result and MW_ReadData are loaded with 0.
- Stores pass EM_RegWrite through unchanged (normally 0). MW_ReadData for a store is 0.
- PCSrc and branch_target are combinational and are never gated by stall (branches are never accesses).
- wcnt is 8 bits and saturates at TIMEOUT.

## Timing
- Reset values: state IDLE, wcnt 0, mem_err 0, and all MW_* outputs 0.
- While reset is high, mem_req=0 and stall=0 (forced asynchronously).
- Latency: the MEM/WB registers update at the first rising edge with stall=0 after the EX/MEM bundle appears.
  - Zero-wait access: 1 cycle.
  - N-wait access: N+1 cycles.
  - Timeout: TIMEOUT+2 cycles.
- Handshake:
  - mem_req is held high until the ack cycle.
  - The request drops in the cycle after ack, or at abort.
  - mem_addr, mem_we and mem_wdata are constant while mem_req=1.
- Back-to-back accesses: after an ack in IDLE or WAIT, the next EX/MEM bundle arrives at that edge. If it is an access, mem_req stays high with the new address; there is no idle cycle.
- mem_ack arriving in ABORT or IDLE without a request is ignored.
- Reset mid-WAIT: mem_req falls immediately and the in-flight access is dropped. The memory must treat a request that drops without ack as cancelled.

## Test plan
- ALU op, EM_RegWrite=1, EM_rd=5, EM_Result=0x1234 → the next edge gives MW_RegWrite=1, MW_rd=5, MW_Result=0x1234; stall never 1.
- Load at addr 0x100 with mem_ack in the same cycle, mem_rdata=0xDEADBEEF → mem_req high for 1 cycle, no stall, MW_ReadData=0xDEADBEEF and MW_MemtoReg=1 at the next edge.
- Store at 0x108, EM_WriteData=0xAA, ack after 3 wait cycles → mem_req and mem_we high for 4 cycles, stall high for 3, three bubbles with MW_RegWrite=0, mem_addr=0x108 throughout.
- TIMEOUT=4, load with no ack → stall high for 5 cycles, mem_req drops in ABORT, mem_err=1, MW_RegWrite=0, mem_err stays set for the following accesses.
- Misaligned load at 0x103, then MemRead and MemWrite both set → no mem_req, no stall, mem_err=1, MW_RegWrite=0 for both.
- Reset asserted in WAIT cycle 2, then EM_Branch=1, EM_zero=1, EM_out=0x400 → mem_req and stall drop at once and all MW_* outputs are 0; after release PCSrc=1 and branch_target=0x400 combinationally.
